// File: rtl/aes_mix_columns_seq_if.sv
// Handshake bundle for the MixColumns engine: block in on one side, transformed block out on the other.
// The engine connects through the slave modport and the block feeding it uses master.
interface aes_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_inv,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_inv,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/aes_mix_columns_seq.sv
// AES MixColumns / InvMixColumns engine that transforms COLS columns per clock, in place,
// in a 128-bit working register. One block in flight, valid/ready on both sides.
module aes_mix_columns_seq #(
  parameter int COLS = 1
) (
  input logic                  clk,
  input logic                  rst,
  aes_mix_columns_seq_if.slave bus
);

  localparam int NCYC = 4 / COLS;
  localparam logic [1:0] LAST_CNT = 2'(NCYC - 1);

  if (!(COLS == 1 || COLS == 2 || COLS == 4)) begin : g_bad_cols
    $error("aes_mix_columns_seq: COLS must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic        mode_reg, mode_next;
  logic [31:0] col_reg [4];
  logic [31:0] col_next [4];
  logic [31:0] col_upd [4];
  logic [31:0] lane_in [COLS];
  logic [31:0] lane_out [COLS];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] r [4];
    for (int i = 0; i < 4; i++) a[i] = col[31 - 8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      r[i] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // 09, 0b, 0d and 0e multiples all come from the same three-deep xtime chain per byte.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] r [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x1[i] = xtime(a[i]);
      x2[i] = xtime(x1[i]);
      x3[i] = xtime(x2[i]);
      m9[i] = x3[i] ^ a[i];
      mb[i] = x3[i] ^ x1[i] ^ a[i];
      md[i] = x3[i] ^ x2[i] ^ a[i];
      me[i] = x3[i] ^ x2[i] ^ x1[i];
    end
    for (int i = 0; i < 4; i++) begin
      r[i] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // Each lane picks its column out of the current group and mixes it in the latched mode.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
    logic [1:0] col_idx;
    assign col_idx      = 2'(int'(cnt_reg) * COLS + gi);
    assign lane_in[gi]  = col_reg[col_idx];
    assign lane_out[gi] = mode_reg ? mix_inv(lane_in[gi]) : mix_fwd(lane_in[gi]);
  end

  // Column gi belongs to group gi/COLS and is served by lane gi%COLS.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    localparam logic [1:0] GROUP = 2'(gi / COLS);
    localparam int SLOT = gi % COLS;
    assign col_upd[gi] = (cnt_reg == GROUP) ? lane_out[SLOT] : col_reg[gi];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    for (int c = 0; c < 4; c++) col_next[c] = col_reg[c];

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = BUSY;
          cnt_next   = 2'd0;
          mode_next  = bus.in_inv;
          for (int c = 0; c < 4; c++) col_next[c] = bus.in_data[127 - 32*c -: 32];
        end
      end
      BUSY: begin
        for (int c = 0; c < 4; c++) col_next[c] = col_upd[c];
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      mode_reg  <= 1'b0;
      for (int c = 0; c < 4; c++) col_reg[c] <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      for (int c = 0; c < 4; c++) col_reg[c] <= col_next[c];
    end
  end

  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_data  = {col_reg[0], col_reg[1], col_reg[2], col_reg[3]};

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Bench for aes_mix_columns_seq: three engines (COLS = 1, 2, 4) checked against a GF(2^8)
// matrix-product model, plus latency, backpressure, input-latching and reset cases.
module tb_aes_mix_columns_seq;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  logic         clk;
  logic         rst;
  logic         in_valid_a [3];
  logic [127:0] in_data_a  [3];
  logic         in_inv_a   [3];
  logic         out_ready_a[3];
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [127:0] out_data_a [3];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes_mix_columns_seq_if bus ();
    assign bus.in_valid     = in_valid_a[gi];
    assign bus.in_data      = in_data_a[gi];
    assign bus.in_inv       = in_inv_a[gi];
    assign bus.out_ready    = out_ready_a[gi];
    assign in_ready_v[gi]   = bus.in_ready;
    assign out_valid_v[gi]  = bus.out_valid;
    assign out_data_a[gi]   = bus.out_data;

    aes_mix_columns_seq #(.COLS(1 << gi)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  // Reference: generic polynomial product reduced by long division, then the 4x4 circulant matrix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] d, input logic inv);
    logic [7:0] coef [4];
    logic [7:0] b [16];
    logic [7:0] r;
    logic [127:0] res = '0;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int k = 0; k < 16; k++) b[k] = d[127 - 8*k -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r ^= gmul(coef[j], b[4*c + (i + j) % 4]);
        res[127 - 8*(4*c + i) -: 8] = r;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input int k, input logic [127:0] d, input logic inv, input string tag);
    int n = 0;
    @(negedge clk);
    in_valid_a[k] = 1'b1;
    in_data_a[k]  = d;
    in_inv_a[k]   = inv;
    while (!in_ready_v[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_k%0d_ready_at_accept", tag, k), 128'(in_ready_v[k]), 128'd1);
    @(posedge clk);
    #1;
    in_valid_a[k] = 1'b0;
  endtask

  // Called just after the accept edge; counts edges from accept (inclusive) to out_valid.
  task automatic wait_done(input int k, input bit scramble, input string tag);
    int lat = 1;
    int busy_ready = 0;
    bit got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid_v[k]) begin
        got = 1'b1;
        break;
      end
      if (in_ready_v[k]) busy_ready++;
      if (scramble) begin
        in_data_a[k] = rand128();
        in_inv_a[k]  = ~in_inv_a[k];
      end
    end
    check($sformatf("%s_k%0d_latency", tag, k), got ? 128'(lat) : 128'hffff, 128'(4 / (1 << k) + 1));
    check($sformatf("%s_k%0d_busy_in_ready", tag, k), 128'(busy_ready), 128'd0);
  endtask

  task automatic finish(input int k, input logic [127:0] exp, input string tag);
    check($sformatf("%s_k%0d_data", tag, k), out_data_a[k], exp);
    @(negedge clk);
    out_ready_a[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[k] = 1'b0;
    check($sformatf("%s_k%0d_post_hs_valid", tag, k), 128'(out_valid_v[k]), 128'd0);
    check($sformatf("%s_k%0d_post_hs_ready", tag, k), 128'(in_ready_v[k]), 128'd1);
  endtask

  task automatic run(input int k, input logic [127:0] d, input logic inv,
                     input logic [127:0] exp, input string tag);
    start(k, d, inv, tag);
    wait_done(k, 1'b0, tag);
    finish(k, exp, tag);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] blk_b;
    logic inv;
    int seen;

    for (int k = 0; k < 3; k++) begin
      in_valid_a[k]  = 1'b0;
      in_data_a[k]   = '0;
      in_inv_a[k]    = 1'b0;
      out_ready_a[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_k%0d_in_ready", k), 128'(in_ready_v[k]), 128'd0);
      check($sformatf("reset_k%0d_out_valid", k), 128'(out_valid_v[k]), 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post_reset_k%0d_in_ready", k), 128'(in_ready_v[k]), 128'd1);
      check($sformatf("post_reset_k%0d_out_data", k), out_data_a[k], 128'h0);
    end

    run(0, {32'hdb135345, 96'h0}, 1'b0, {32'h8e4da1bc, 96'h0}, "col0");

    for (int k = 0; k < 3; k++) begin
      run(k, FIPS_IN, 1'b0, FIPS_OUT, "fips_fwd");
      run(k, FIPS_OUT, 1'b1, FIPS_IN, "fips_inv");
      d = {32'hc6c6c6c6, 32'h01010101, 32'h01010101, 32'hc6c6c6c6};
      run(k, d, 1'b0, d, "fixed_fwd");
      run(k, d, 1'b1, d, "fixed_inv");
    end

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 6; n++) begin
        d   = rand128();
        inv = 1'($urandom_range(0, 1));
        run(k, d, inv, mix_ref(d, inv), $sformatf("rand%0d", n));
      end
    end

    // Backpressure: a finished block is held while a second one waits at the input.
    blk_b = rand128();
    start(0, FIPS_IN, 1'b0, "bp");
    wait_done(0, 1'b0, "bp");
    @(negedge clk);
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = blk_b;
    in_inv_a[0]   = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_data", n), out_data_a[0], FIPS_OUT);
      check($sformatf("bp_hold%0d_in_ready", n), 128'(in_ready_v[0]), 128'd0);
      check($sformatf("bp_hold%0d_out_valid", n), 128'(out_valid_v[0]), 128'd1);
    end
    @(negedge clk);
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[0] = 1'b0;
    check("bp_release_out_valid", 128'(out_valid_v[0]), 128'd0);
    check("bp_release_in_ready", 128'(in_ready_v[0]), 128'd1);
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    check("bp_second_accepted", 128'(in_ready_v[0]), 128'd0);
    wait_done(0, 1'b0, "bp2");
    finish(0, mix_ref(blk_b, 1'b1), "bp2");

    // Inputs wander while busy; only the accept-cycle values may matter.
    start(0, FIPS_IN, 1'b0, "latch");
    wait_done(0, 1'b1, "latch");
    finish(0, FIPS_OUT, "latch");

    // Reset with cnt=1 in BUSY: block is dropped silently.
    start(0, FIPS_IN, 1'b0, "rst_busy");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy_in_ready_during", 128'(in_ready_v[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy_in_ready_after", 128'(in_ready_v[0]), 128'd1);
    check("rst_busy_out_valid", 128'(out_valid_v[0]), 128'd0);
    check("rst_busy_out_data", out_data_a[0], 128'h0);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (out_valid_v[0]) seen++;
    end
    check("rst_busy_no_out_valid", 128'(seen), 128'd0);
    d = rand128();
    run(0, d, 1'b0, mix_ref(d, 1'b0), "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
